// File: rtl/bpu_btb.sv
// Direct-mapped BTB with 2-bit counters: zero-latency IF lookup, EX training.
// Optional BPU_STATS_EN adds saturating update/mispredict counters.
module bpu_btb #(
  parameter int PC_WIDTH = 8,
  parameter int ENTRIES  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pc_f,
  output logic                hit_f,
  output logic                pred_taken_f,
  output logic [PC_WIDTH-1:0] pred_target_f,
  input  logic                upd_valid_e,
  input  logic [PC_WIDTH-1:0] upd_pc_e,
  input  logic                upd_is_jump_e,
  input  logic                upd_taken_e,
  input  logic [PC_WIDTH-1:0] upd_target_e,
  input  logic                pred_taken_e,
  input  logic [PC_WIDTH-1:0] pred_target_e,
  output logic                mispredict_e,
  output logic [PC_WIDTH-1:0] redirect_pc_e
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]         stat_updates,
  output logic [31:0]         stat_mispredicts
`endif
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX - 2;
  localparam logic [PC_WIDTH-1:0] PC_INC = PC_WIDTH'(4);

  logic                valid_q  [ENTRIES];
  logic                valid_d  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [TAG_W-1:0]    tag_d    [ENTRIES];
  logic [PC_WIDTH-1:0] target_q [ENTRIES];
  logic [PC_WIDTH-1:0] target_d [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [1:0]          ctr_d    [ENTRIES];
  logic                jump_q   [ENTRIES];
  logic                jump_d   [ENTRIES];

  logic [IDX-1:0]   idx_f;
  logic [IDX-1:0]   idx_e;
  logic [TAG_W-1:0] tag_f;
  logic [TAG_W-1:0] tag_e;
  logic             hit_e;
  logic [1:0]       ctr_e;

  always_comb begin
    idx_f = pc_f[IDX+1:2];
    tag_f = pc_f[PC_WIDTH-1:IDX+2];
    hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    pred_taken_f = hit_f && (jump_q[idx_f] || ctr_q[idx_f][1]);
    pred_target_f = pred_taken_f ? target_q[idx_f]
                                 : pc_f + PC_INC;
  end

  always_comb begin
    mispredict_e  = 1'b0;
    redirect_pc_e = '0;
    if (upd_valid_e) begin
      mispredict_e = (pred_taken_e != upd_taken_e) ||
                     (pred_taken_e && upd_taken_e &&
                      (pred_target_e != upd_target_e));
      redirect_pc_e = upd_taken_e ? upd_target_e
                                  : upd_pc_e + PC_INC;
    end
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    jump_d   = jump_q;
    idx_e    = upd_pc_e[IDX+1:2];
    tag_e    = upd_pc_e[PC_WIDTH-1:IDX+2];
    hit_e    = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    ctr_e    = ctr_q[idx_e];
    if (upd_valid_e) begin
      unique case (1'b1)
        hit_e && upd_is_jump_e: begin
          ctr_d[idx_e]    = 2'b11;
          target_d[idx_e] = upd_target_e;
        end
        hit_e && !upd_is_jump_e && upd_taken_e: begin
          ctr_d[idx_e]    = (ctr_e == 2'b11) ? 2'b11
                                             : ctr_e + 2'd1;
          target_d[idx_e] = upd_target_e;
        end
        hit_e && !upd_is_jump_e && !upd_taken_e: begin
          ctr_d[idx_e] = (ctr_e == 2'b00) ? 2'b00
                                          : ctr_e - 2'd1;
        end
        !hit_e && upd_taken_e: begin
          valid_d[idx_e]  = 1'b1;
          tag_d[idx_e]    = tag_e;
          target_d[idx_e] = upd_target_e;
          jump_d[idx_e]   = upd_is_jump_e;
          ctr_d[idx_e]    = upd_is_jump_e ? 2'b11 : 2'b10;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '{default: '0};
      tag_q    <= '{default: '0};
      target_q <= '{default: '0};
      ctr_q    <= '{default: '0};
      jump_q   <= '{default: '0};
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
      jump_q   <= jump_d;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] upd_cnt_q;
  logic [31:0] upd_cnt_d;
  logic [31:0] mis_cnt_q;
  logic [31:0] mis_cnt_d;

  always_comb begin
    upd_cnt_d = upd_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (upd_valid_e && (upd_cnt_q != '1))
      upd_cnt_d = upd_cnt_q + 32'd1;
    if (mispredict_e && (mis_cnt_q != '1))
      mis_cnt_d = mis_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      upd_cnt_q <= upd_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign stat_updates     = upd_cnt_q;
  assign stat_mispredicts = mis_cnt_q;
`endif

endmodule

// File: tb/tb_bpu_btb.sv
// Directed self-checking bench for bpu_btb.
// Expected values are hand-computed for PC_WIDTH=8, ENTRIES=8.
module tb_bpu_btb;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pc_f;
  logic       hit_f;
  logic       pred_taken_f;
  logic [7:0] pred_target_f;
  logic       upd_valid_e;
  logic [7:0] upd_pc_e;
  logic       upd_is_jump_e;
  logic       upd_taken_e;
  logic [7:0] upd_target_e;
  logic       pred_taken_e;
  logic [7:0] pred_target_e;
  logic       mispredict_e;
  logic [7:0] redirect_pc_e;
`ifdef BPU_STATS_EN
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;
`endif

  int checks = 0;
  int errors = 0;

  bpu_btb #(.PC_WIDTH(8), .ENTRIES(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_f          (pc_f),
    .hit_f         (hit_f),
    .pred_taken_f  (pred_taken_f),
    .pred_target_f (pred_target_f),
    .upd_valid_e   (upd_valid_e),
    .upd_pc_e      (upd_pc_e),
    .upd_is_jump_e (upd_is_jump_e),
    .upd_taken_e   (upd_taken_e),
    .upd_target_e  (upd_target_e),
    .pred_taken_e  (pred_taken_e),
    .pred_target_e (pred_target_e),
    .mispredict_e  (mispredict_e),
    .redirect_pc_e (redirect_pc_e)
`ifdef BPU_STATS_EN
    ,
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0b, want %0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [7:0] pc, input logic jmp,
                     input logic tk, input logic [7:0] tgt,
                     input logic ptk, input logic [7:0] ptgt);
    upd_valid_e   = 1'b1;
    upd_pc_e      = pc;
    upd_is_jump_e = jmp;
    upd_taken_e   = tk;
    upd_target_e  = tgt;
    pred_taken_e  = ptk;
    pred_target_e = ptgt;
    #1;
  endtask

  task automatic idle();
    upd_valid_e = 1'b0;
    #1;
  endtask

  task automatic look(input logic [7:0] pc);
    pc_f = pc;
    #1;
  endtask

  task automatic chk_stats(input string tag, input int u,
                           input int m);
`ifdef BPU_STATS_EN
    chk32({tag, "_upd"}, stat_updates, u);
    chk32({tag, "_mis"}, stat_mispredicts, m);
`endif
  endtask

  initial begin
    rst = 1'b1;
    pc_f = 8'h00;
    upd_valid_e = 1'b0;
    upd_pc_e = 8'h00;
    upd_is_jump_e = 1'b0;
    upd_taken_e = 1'b0;
    upd_target_e = 8'h00;
    pred_taken_e = 1'b0;
    pred_target_e = 8'h00;
    tick();
    rst = 1'b0;
    look(8'h10);
    chk1("rst_hit", hit_f, 1'b0);
    chk1("rst_ptk", pred_taken_f, 1'b0);
    chk8("rst_tgt", pred_target_f, 8'h14);
    chk1("rst_mis", mispredict_e, 1'b0);
    chk8("rst_redir", redirect_pc_e, 8'h00);
    chk_stats("rst", 0, 0);

    upd(8'h10, 1'b0, 1'b1, 8'h40, 1'b0, 8'h14);
    chk1("alloc_mis", mispredict_e, 1'b1);
    chk8("alloc_redir", redirect_pc_e, 8'h40);
    chk1("alloc_coll_hit", hit_f, 1'b0);
    tick();
    idle();
    chk1("alloc_hit", hit_f, 1'b1);
    chk1("alloc_ptk", pred_taken_f, 1'b1);
    chk8("alloc_tgt", pred_target_f, 8'h40);
    chk_stats("alloc", 1, 1);

    upd(8'h10, 1'b0, 1'b0, 8'h40, 1'b1, 8'h40);
    chk1("nt1_mis", mispredict_e, 1'b1);
    chk8("nt1_redir", redirect_pc_e, 8'h14);
    chk1("nt1_coll_ptk", pred_taken_f, 1'b1);
    tick();
    idle();
    chk1("ctr1_hit", hit_f, 1'b1);
    chk1("ctr1_ptk", pred_taken_f, 1'b0);
    chk8("ctr1_tgt", pred_target_f, 8'h14);

    upd(8'h10, 1'b0, 1'b0, 8'h40, 1'b0, 8'h14);
    chk1("nt2_mis", mispredict_e, 1'b0);
    chk8("nt2_redir", redirect_pc_e, 8'h14);
    tick();
    upd(8'h10, 1'b0, 1'b1, 8'h40, 1'b0, 8'h14);
    chk1("t1_mis", mispredict_e, 1'b1);
    tick();
    idle();
    chk1("ctr1b_ptk", pred_taken_f, 1'b0);
    upd(8'h10, 1'b0, 1'b1, 8'h40, 1'b0, 8'h14);
    tick();
    idle();
    chk1("ctr2_ptk", pred_taken_f, 1'b1);
    chk8("ctr2_tgt", pred_target_f, 8'h40);

    upd(8'h10, 1'b0, 1'b1, 8'h40, 1'b1, 8'h40);
    chk1("ok_mis", mispredict_e, 1'b0);
    chk8("ok_redir", redirect_pc_e, 8'h40);
    tick();
    upd(8'h10, 1'b0, 1'b1, 8'h40, 1'b1, 8'h40);
    tick();
    upd(8'h10, 1'b0, 1'b0, 8'h40, 1'b1, 8'h40);
    tick();
    idle();
    chk1("sat_ptk", pred_taken_f, 1'b1);

    upd(8'h10, 1'b0, 1'b1, 8'h44, 1'b1, 8'h40);
    chk1("wt_mis", mispredict_e, 1'b1);
    chk8("wt_redir", redirect_pc_e, 8'h44);
    tick();
    idle();
    chk8("wt_tgt", pred_target_f, 8'h44);
    chk_stats("wt", 9, 6);

    upd(8'h30, 1'b1, 1'b1, 8'h08, 1'b0, 8'h34);
    chk1("jmp_mis", mispredict_e, 1'b1);
    tick();
    idle();
    chk1("alias_hit", hit_f, 1'b0);
    chk1("alias_ptk", pred_taken_f, 1'b0);
    chk8("alias_tgt", pred_target_f, 8'h14);
    look(8'h30);
    chk1("jmp_hit", hit_f, 1'b1);
    chk1("jmp_ptk", pred_taken_f, 1'b1);
    chk8("jmp_tgt", pred_target_f, 8'h08);

    upd(8'h50, 1'b0, 1'b0, 8'h00, 1'b0, 8'h54);
    chk1("mnt_mis", mispredict_e, 1'b0);
    chk8("mnt_redir", redirect_pc_e, 8'h54);
    tick();
    idle();
    chk1("mnt_keep_hit", hit_f, 1'b1);

    look(8'hFC);
    chk1("wrap_hit", hit_f, 1'b0);
    chk8("wrap_tgt", pred_target_f, 8'h00);
    upd(8'hFC, 1'b0, 1'b0, 8'h00, 1'b1, 8'h80);
    chk1("wrap_mis", mispredict_e, 1'b1);
    chk8("wrap_redir", redirect_pc_e, 8'h00);
    tick();
    idle();
    chk_stats("pre_rst", 12, 8);

    rst = 1'b1;
    upd(8'h20, 1'b0, 1'b1, 8'h60, 1'b0, 8'h24);
    tick();
    rst = 1'b0;
    idle();
    look(8'h20);
    chk1("rstw_hit", hit_f, 1'b0);
    look(8'h30);
    chk1("rstclr_hit", hit_f, 1'b0);
    chk8("rstclr_tgt", pred_target_f, 8'h34);
    chk_stats("rst2", 0, 0);

    upd_pc_e = 8'h10;
    upd_taken_e = 1'b1;
    upd_target_e = 8'h40;
    pred_taken_e = 1'b0;
    #1;
    chk1("inv_mis", mispredict_e, 1'b0);
    chk8("inv_redir", redirect_pc_e, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
